// File: rtl/tqvp_peri_fabric.sv
// tqvp_peri_fabric: tinyQV peripheral interconnect. It decodes 64-byte slots
// and holds read data until the core completes the read. It also contains
// the GPIO / pin-mux register bank.
// Slot 0 is unmapped, slot 1 is GPIO, and slots 2..NUM_PERI+1 are
// peripherals 0..NUM_PERI-1. Any other slot is unmapped.
// Optional read watchdog and sticky bus error: define PERI_FABRIC_TIMEOUT_EN.
// Ports:
//   clk, rst_n (sync, active-low)
//   addr_in, data_in, data_write_n, data_read_n, data_read_complete,
//   data_out, data_ready            : core peripheral bus
//   ui_in, uo_out                   : GPIO pins
//   peri_write_n, peri_read_n       : per-peripheral strobes
//   peri_data_out, peri_data_ready,
//   peri_uo_out                     : per-peripheral data, ready and pins
//   err_irq                         : sticky bus-error interrupt
module tqvp_peri_fabric #(
    parameter int NUM_PERI       = 4,
    parameter int NUM_PINS       = 8,
    parameter int FSEL_W         = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [10:0]                  addr_in,
    input  logic [31:0]                  data_in,
    input  logic [1:0]                   data_write_n,
    input  logic [1:0]                   data_read_n,
    input  logic                         data_read_complete,
    output logic [31:0]                  data_out,
    output logic                         data_ready,
    input  logic [NUM_PINS-1:0]          ui_in,
    output logic [NUM_PINS-1:0]          uo_out,
    output logic [2*NUM_PERI-1:0]        peri_write_n,
    output logic [2*NUM_PERI-1:0]        peri_read_n,
    input  logic [32*NUM_PERI-1:0]       peri_data_out,
    input  logic [NUM_PERI-1:0]          peri_data_ready,
    input  logic [NUM_PINS*NUM_PERI-1:0] peri_uo_out,
    output logic                         err_irq
);

    logic [4:0] slot;
    logic [5:0] offset;
    logic       write_req;
    logic       read_req;
    logic       is_gpio;
    logic       is_peri;
    logic       gpio_we;
    int         pidx;

    assign slot      = addr_in[10:6];
    assign offset    = addr_in[5:0];
    assign write_req = (data_write_n != 2'b11);
    assign read_req  = (data_read_n != 2'b11);
    assign is_gpio   = (slot == 5'd1);
    assign pidx      = int'(slot) - 2;
    assign is_peri   = (pidx >= 0) && (pidx < NUM_PERI);
    assign gpio_we   = write_req && is_gpio;

    logic [31:0]                    data_q, data_d;
    logic                           data_ready_q, data_ready_d;
    logic                           hold_q, hold_d;
    logic [NUM_PINS-1:0]            out_q, out_d;
    logic [NUM_PINS-1:0][FSEL_W-1:0] fsel_q, fsel_d;

    logic        base_ready;
    logic        sel_ready;
    logic [31:0] sel_data;
    logic [31:0] rdata;
    logic [31:0] gpio_rdata;
    logic        timeout;
    logic        err_bit;

    // Strobes reach only the selected peripheral.
    // The read strobe is masked in the response cycle, so each transfer
    // produces exactly one peripheral read.
    always_comb begin
        peri_write_n = '1;
        peri_read_n  = '1;
        if (is_peri) begin
            peri_write_n[2*pidx +: 2] = data_write_n;
            peri_read_n[2*pidx +: 2]  = data_read_n | {2{data_ready_q}};
        end
    end

    always_comb begin
        gpio_rdata = '0;
        if (offset[5]) begin
            for (int k = 0; k < NUM_PINS; k++) begin
                if (offset[4:2] == 3'(k)) begin
                    gpio_rdata[FSEL_W-1:0] = fsel_q[k];
                end
            end
        end else begin
            case (offset[4:2])
                3'd0:    gpio_rdata[NUM_PINS-1:0] = out_q;
                3'd1:    gpio_rdata[NUM_PINS-1:0] = ui_in;
                3'd5:    gpio_rdata[0] = err_bit;
                default: gpio_rdata = '0;
            endcase
        end
    end

    always_comb begin
        base_ready = 1'b1;
        sel_data   = '0;
        if (is_gpio) begin
            sel_data = gpio_rdata;
        end else if (is_peri) begin
            base_ready = peri_data_ready[pidx];
            sel_data   = peri_data_out[32*pidx +: 32];
        end
    end

    assign sel_ready = base_ready | timeout;
    assign rdata     = timeout ? (32'hBADB_0000 | {21'b0, addr_in})
                               : sel_data;

    // Capture wins over a completion arriving in the same cycle.
    always_comb begin
        data_ready_d = read_req & sel_ready;
        hold_d       = hold_q & ~data_read_complete;
        data_d       = data_q;
        if (read_req && sel_ready && !hold_q) begin
            data_d = rdata;
            hold_d = 1'b1;
        end
    end

    // SET/CLR/TGL operate on the current OUT value.
    always_comb begin
        out_d  = out_q;
        fsel_d = fsel_q;
        if (gpio_we) begin
            if (offset[5]) begin
                for (int k = 0; k < NUM_PINS; k++) begin
                    if (offset[4:2] == 3'(k)) begin
                        fsel_d[k] = data_in[FSEL_W-1:0];
                    end
                end
            end else begin
                case (offset[4:2])
                    3'd0:    out_d = data_in[NUM_PINS-1:0];
                    3'd2:    out_d = out_q | data_in[NUM_PINS-1:0];
                    3'd3:    out_d = out_q & ~data_in[NUM_PINS-1:0];
                    3'd4:    out_d = out_q ^ data_in[NUM_PINS-1:0];
                    default: out_d = out_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q       <= '0;
            data_ready_q <= 1'b0;
            hold_q       <= 1'b0;
            out_q        <= '0;
            for (int k = 0; k < NUM_PINS; k++) begin
                fsel_q[k] <= (k < 2) ? FSEL_W'(2) : FSEL_W'(1);
            end
        end else begin
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
            hold_q       <= hold_d;
            out_q        <= out_d;
            fsel_q       <= fsel_d;
        end
    end

    always_comb begin
        int v;
        v      = 0;
        uo_out = '0;
        for (int k = 0; k < NUM_PINS; k++) begin
            v = int'(fsel_q[k]);
            if (v == 1) begin
                uo_out[k] = out_q[k];
            end else if (v >= 2 && v <= NUM_PERI + 1) begin
                uo_out[k] = peri_uo_out[(v-2)*NUM_PINS + k];
            end
        end
    end

    assign data_out   = data_q;
    assign data_ready = write_req | data_ready_q;

`ifdef PERI_FABRIC_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  slot_q;
    logic        rd_q;
    logic        err_q, err_d;

    assign timeout = read_req && !base_ready
                     && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // A slot change only restarts the count while a read is in flight.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!read_req || base_ready || timeout
            || (rd_q && slot != slot_q)) begin
            cnt_d = '0;
        end
        err_d = err_q;
        if (gpio_we && offset[5:2] == 4'd5 && data_in[0]) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            slot_q <= '0;
            rd_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot;
            rd_q   <= read_req;
            err_q  <= err_d;
        end
    end

    assign err_bit = err_q;
    assign err_irq = err_q;
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
    assign err_bit        = 1'b0;
    assign err_irq        = 1'b0;
`endif

    logic unused_ok;

    assign unused_ok = &{1'b0, data_in, addr_in[1:0]};

endmodule

// File: tb/tb_tqvp_peri_fabric.sv
// Bench for tqvp_peri_fabric: behavioural model plus per-cycle compare,
// and directed vectors with literal expectations.
module tb_tqvp_peri_fabric;

    localparam int NP = 4;
`ifdef PERI_FABRIC_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic [10:0] addr_in;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic        data_read_complete;
    logic [31:0] data_out;
    logic        data_ready;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [7:0]  peri_write_n;
    logic [7:0]  peri_read_n;
    logic [127:0] peri_data_out;
    logic [3:0]  peri_data_ready;
    logic [31:0] peri_uo_out;
    logic        err_irq;

    tqvp_peri_fabric #(
        .NUM_PERI(NP), .NUM_PINS(8), .FSEL_W(5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_read_complete(data_read_complete), .data_out(data_out),
        .data_ready(data_ready), .ui_in(ui_in), .uo_out(uo_out),
        .peri_write_n(peri_write_n), .peri_read_n(peri_read_n),
        .peri_data_out(peri_data_out), .peri_data_ready(peri_data_ready),
        .peri_uo_out(peri_uo_out), .err_irq(err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    logic chk_en;

    // Model state
    logic [7:0]  out_m;
    logic [4:0]  fsel_m [8];
    logic        err_m;
    logic [31:0] dm;
    logic        hold_m;
    logic        rdy_m;
    int          cnt_m;
    int          pslot_m;
    logic        prq_m;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] gpio_val(input logic [5:0] off);
        logic [31:0] r;
        r = '0;
        if (off[5]) r = {27'b0, fsel_m[off[4:2]]};
        else if (off[4:2] == 3'd0) r = {24'b0, out_m};
        else if (off[4:2] == 3'd1) r = {24'b0, ui_in};
        else if (off[4:2] == 3'd5) r = {31'b0, err_m};
        return r;
    endfunction

    always @(posedge clk) begin : model
        int s;
        logic rq, br, to, wr;
        logic [31:0] rv;
        s  = int'(addr_in[10:6]);
        rq = (data_read_n != 2'b11);
        wr = (data_write_n != 2'b11);
        br = 1'b1;
        if (s >= 2 && s <= NP + 1) br = peri_data_ready[s-2];
        to = 1'b0;
`ifdef PERI_FABRIC_TIMEOUT_EN
        to = rq && !br && (cnt_m == TO - 1);
`endif
        rv = '0;
        if (to) rv = 32'hBADB_0000 | {21'b0, addr_in};
        else if (s == 1) rv = gpio_val(addr_in[5:0]);
        else if (s >= 2 && s <= NP + 1) rv = peri_data_out[(s-2)*32 +: 32];
        if (!rst_n) begin
            out_m = '0;
            for (int k = 0; k < 8; k++) fsel_m[k] = (k < 2) ? 5'd2 : 5'd1;
            err_m = 0; dm = '0; hold_m = 0; rdy_m = 0;
            cnt_m = 0; pslot_m = 0; prq_m = 0;
        end else begin
            if (rq && (br || to) && !hold_m) begin
                dm = rv;
                hold_m = 1;
            end else if (data_read_complete) begin
                hold_m = 0;
            end
            rdy_m = rq && (br || to);
`ifdef PERI_FABRIC_TIMEOUT_EN
            if (!rq || br || to || (prq_m && s != pslot_m)) cnt_m = 0;
            else cnt_m = cnt_m + 1;
            if (to) err_m = 1;
            else if (s == 1 && wr && addr_in[5:2] == 4'd5 && data_in[0])
                err_m = 0;
`endif
            if (s == 1 && wr) begin
                if (addr_in[5]) fsel_m[addr_in[4:2]] = data_in[4:0];
                else if (addr_in[4:2] == 3'd0) out_m = data_in[7:0];
                else if (addr_in[4:2] == 3'd2) out_m = out_m | data_in[7:0];
                else if (addr_in[4:2] == 3'd3) out_m = out_m & ~data_in[7:0];
                else if (addr_in[4:2] == 3'd4) out_m = out_m ^ data_in[7:0];
            end
            pslot_m = s;
            prq_m = rq;
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] eu, ew, er;
        int v, s;
        if (chk_en) begin
            eu = '0;
            for (int k = 0; k < 8; k++) begin
                v = int'(fsel_m[k]);
                if (v == 1) eu[k] = out_m[k];
                else if (v >= 2 && v <= NP + 1) eu[k] = peri_uo_out[(v-2)*8 + k];
            end
            s = int'(addr_in[10:6]);
            ew = '1;
            er = '1;
            for (int i = 0; i < NP; i++) begin
                if (s == i + 2) begin
                    ew[2*i +: 2] = data_write_n;
                    er[2*i +: 2] = data_read_n | {2{rdy_m}};
                end
            end
            chk("m_data_out", data_out, dm);
            chk("m_data_ready", {31'b0, data_ready},
                {31'b0, (data_write_n != 2'b11) | rdy_m});
            chk("m_uo_out", {24'b0, uo_out}, {24'b0, eu});
            chk("m_peri_write_n", {24'b0, peri_write_n}, {24'b0, ew});
            chk("m_peri_read_n", {24'b0, peri_read_n}, {24'b0, er});
            chk("m_err_irq", {31'b0, err_irq}, {31'b0, err_m});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        addr_in = a;
        data_in = d;
        data_write_n = 2'b10;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [10:0] a, input logic [31:0] exp,
                      input string nm, output int lat);
        int n;
        n = 0;
        addr_in = a;
        data_read_n = 2'b10;
        @(negedge clk);
        while (!data_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=none want=data_ready", nm);
        end
        chk(nm, data_out, exp);
        lat = n;
        @(posedge clk);
        #1;
        data_read_n = 2'b11;
        data_read_complete = 1'b1;
        tick();
        data_read_complete = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        checks = 0;
        failures = 0;
        chk_en = 0;
        rst_n = 0;
        addr_in = '0;
        data_in = '0;
        data_write_n = 2'b11;
        data_read_n = 2'b11;
        data_read_complete = 0;
        ui_in = 8'h5A;
        peri_data_out = '0;
        peri_data_ready = 4'b0001;
        peri_uo_out = 32'h0000_00A6;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk_en = 1;

        @(negedge clk);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_data_ready", {31'b0, data_ready}, 32'h0);
        chk("rst_uo_out", {24'b0, uo_out}, 32'h02);
        chk("rst_err_irq", {31'b0, err_irq}, 32'h0);
        tick();

        rd(11'h060, 32'd2, "rd_fsel0", lat);
        chk("gpio_latency", lat, 1);
        rd(11'h068, 32'd1, "rd_fsel2", lat);
        rd(11'h040, 32'd0, "rd_out_rst", lat);

        wr(11'h040, 32'h0F);
        wr(11'h048, 32'h30);
        wr(11'h04C, 32'h03);
        wr(11'h050, 32'h81);
        rd(11'h040, 32'hBD, "rd_out_ops", lat);
        @(negedge clk);
        chk("uo_out_ops", {24'b0, uo_out}, 32'hBE);
        tick();
        rd(11'h044, 32'h5A, "rd_in", lat);
        rd(11'h048, 32'h0, "rd_set_wo", lat);
        rd(11'h07C, 32'h1, "rd_fsel7", lat);
        rd(11'h004, 32'h0, "rd_slot0", lat);
        rd(11'h180, 32'h0, "rd_slot6", lat);
        wr(11'h000, 32'hFF);
        wr(11'h080, 32'h1);
        rd(11'h040, 32'hBD, "rd_out_unmapped_wr", lat);

        // Peripheral 1 (slot 3), ready three cycles late
        peri_data_ready = 4'b0000;
        peri_data_out[63:32] = 32'h1234_5678;
        addr_in = 11'h0C4;
        data_read_n = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pr_wait", {31'b0, data_ready}, 32'h0);
            chk("pr_strobe", {30'b0, peri_read_n[3:2]}, 32'h2);
        end
        tick();
        peri_data_ready[1] = 1'b1;
        @(negedge clk);
        chk("pr_not_yet", {31'b0, data_ready}, 32'h0);
        @(negedge clk);
        chk("pr_ready", {31'b0, data_ready}, 32'h1);
        chk("pr_data", data_out, 32'h1234_5678);
        chk("pr_mask", {30'b0, peri_read_n[3:2]}, 32'h3);
        tick();
        peri_data_out[63:32] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("pr_hold", data_out, 32'h1234_5678);
        tick();
        data_read_n = 2'b11;
        data_read_complete = 1'b1;
        peri_data_ready = 4'b0001;
        tick();
        data_read_complete = 1'b0;

        // Pin 5 routed to peripheral 1, then to an out-of-range select
        wr(11'h074, 32'd3);
        peri_uo_out[13] = 1'b1;
        @(negedge clk);
        chk("mux_p1_hi", {31'b0, uo_out[5]}, 32'h1);
        tick();
        peri_uo_out[13] = 1'b0;
        @(negedge clk);
        chk("mux_p1_lo", {31'b0, uo_out[5]}, 32'h0);
        tick();
        wr(11'h074, 32'd31);
        peri_uo_out[13] = 1'b1;
        @(negedge clk);
        chk("mux_fsel31", {31'b0, uo_out[5]}, 32'h0);
        tick();
        peri_uo_out[13] = 1'b0;

`ifdef PERI_FABRIC_TIMEOUT_EN
        begin
            int n;
            n = 0;
            addr_in = 11'h10C;
            data_read_n = 2'b10;
            @(negedge clk);
            while (!data_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("to_latency", n, 16);
            chk("to_data", data_out, 32'hBADB_010C);
            chk("to_irq", {31'b0, err_irq}, 32'h1);
            tick();
            data_read_n = 2'b11;
            data_read_complete = 1'b1;
            tick();
            data_read_complete = 1'b0;
            rd(11'h054, 32'h1, "err_read", lat);
            wr(11'h054, 32'h1);
            @(negedge clk);
            chk("err_clr", {31'b0, err_irq}, 32'h0);
            tick();
            rd(11'h054, 32'h0, "err_read_clr", lat);
        end
`else
        rd(11'h054, 32'h0, "err_absent", lat);
        wr(11'h054, 32'h1);
        @(negedge clk);
        chk("err_irq_tied", {31'b0, err_irq}, 32'h0);
        tick();
`endif

        // Reset during a pending read
        wr(11'h060, 32'd7);
        peri_data_out[31:0] = 32'hCAFE_F00D;
        addr_in = 11'h080;
        data_read_n = 2'b10;
        tick();
        chk("mid_ready", {31'b0, data_ready}, 32'h1);
        chk("mid_data", data_out, 32'hCAFE_F00D);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ready", {31'b0, data_ready}, 32'h0);
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_uo", {24'b0, uo_out}, 32'h02);
        rst_n = 1'b1;
        data_read_n = 2'b11;
        tick();
        rd(11'h060, 32'd2, "post_rst_fsel0", lat);
        rd(11'h040, 32'd0, "post_rst_out", lat);

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
